// File: rtl/comb_dp_rr_scheduler.sv
// rtl/comb_dp_rr_scheduler.sv - round-robin time-sharing of one combinational datapath
// Grants one requester, drives its operands onto dp_in, waits the settle time, returns dp_out.
module comb_dp_rr_scheduler #(
  parameter int NREQ     = 4,
  parameter int IW       = 28,
  parameter int OW       = 18,
  parameter int SETTLE_W = 4,
  localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*IW-1:0]  req_data,
  input  logic [SETTLE_W-1:0] settle_cyc,
  output logic [IW-1:0]       dp_in,
  input  logic [OW-1:0]       dp_out,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [OW-1:0]       rsp_data,
  output logic [IDW-1:0]      rsp_id,
  output logic                busy
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RESP} state_t;

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  state_t              state, state_next;
  logic [IDW-1:0]      rr_ptr;
  logic [SETTLE_W-1:0] cnt;
  logic                found;
  logic [IDW-1:0]      grant_idx;
  logic [IDW:0]        sum;
  logic [SETTLE_W-1:0] settle_eff;

  // Circular search for the first valid requester at or after rr_ptr.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    sum       = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, rr_ptr} + (IDW+1)'(i);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      if (!found && req_valid[sum[IDW-1:0]]) begin
        found     = 1'b1;
        grant_idx = sum[IDW-1:0];
      end
    end
  end

  assign settle_eff = (settle_cyc == '0) ? SETTLE_W'(1) : settle_cyc;
  assign req_ready  = (state == S_IDLE && found) ? (NREQ'(1) << grant_idx) : '0;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (found) state_next = S_SETTLE;
      S_SETTLE: if (cnt <= SETTLE_W'(1)) state_next = S_RESP;
      S_RESP:   if (rsp_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      cnt       <= '0;
      dp_in     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            dp_in  <= req_data[grant_idx*IW +: IW];
            rsp_id <= grant_idx;
            rr_ptr <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
            cnt    <= settle_eff;
          end
        end
        S_SETTLE: begin
          // Capture on the last settle cycle; dp_in stays driven until the next grant.
          if (cnt <= SETTLE_W'(1)) begin
            rsp_data  <= dp_out;
            rsp_valid <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt - SETTLE_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_comb_dp_rr_scheduler.sv
// tb/tb_comb_dp_rr_scheduler.sv - randomized bench with a transaction-level arbiter model
module tb_comb_dp_rr_scheduler;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [111:0] req_data;
  logic [3:0]   settle_cyc;
  logic [27:0]  dp_in;
  logic [17:0]  dp_out;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [17:0]  rsp_data;
  logic [1:0]   rsp_id;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;
  logic [27:0] dat [4];

  comb_dp_rr_scheduler #(.NREQ(4), .IW(28), .OW(18), .SETTLE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .settle_cyc(settle_cyc), .dp_in(dp_in), .dp_out(dp_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .busy(busy)
  );

  // Benchmark netlist stand-in: outputs follow the low input bits.
  assign dp_out = dp_in[17:0];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int pick(input int p, input logic [3:0] v);
    for (int i = 0; i < 4; i++)
      if (v[(p + i) % 4]) return (p + i) % 4;
    return 0;
  endfunction

  task automatic do_txn(input logic [3:0] v, input int s, input bit early,
                        input int stall, input bit fixed);
    int g;
    int lat;
    logic [27:0] exp_in;
    for (int k = 0; k < 4; k++) begin
      dat[k] = 28'($urandom());
      if (fixed && k == 2) dat[k] = 28'h0ABCDEF;
      req_data[k*28 +: 28] = dat[k];
    end
    req_valid  = v;
    settle_cyc = 4'(s);
    rsp_ready  = early;
    #1;
    g = pick(m_ptr, v);
    chk("grant_ready", 64'(req_ready), 64'(1) << g);
    chk("idle_busy", 64'(busy), 64'd0);
    adv();
    settle_cyc = 4'hF;
    lat = (s == 0) ? 1 : s;
    exp_in = dat[g];
    chk("dp_in", 64'(dp_in), 64'(exp_in));
    chk("settle_valid", 64'(rsp_valid), 64'd0);
    chk("settle_busy", 64'(busy), 64'd1);
    chk("settle_ready", 64'(req_ready), 64'd0);
    for (int j = 1; j < lat; j++) begin
      adv();
      chk("settle_valid", 64'(rsp_valid), 64'd0);
      chk("settle_ready", 64'(req_ready), 64'd0);
    end
    adv();
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rsp_data", 64'(rsp_data), 64'(exp_in[17:0]));
    chk("rsp_id", 64'(rsp_id), 64'(g));
    if (!early) begin
      repeat (stall) begin
        adv();
        chk("hold_valid", 64'(rsp_valid), 64'd1);
        chk("hold_data", 64'(rsp_data), 64'(exp_in[17:0]));
        chk("hold_id", 64'(rsp_id), 64'(g));
        chk("hold_ready", 64'(req_ready), 64'd0);
      end
      rsp_ready = 1'b1;
    end
    adv();
    chk("accept_valid", 64'(rsp_valid), 64'd0);
    chk("accept_busy", 64'(busy), 64'd0);
    rsp_ready = 1'b0;
    req_valid = 4'd0;
    m_ptr = (g + 1) % 4;
  endtask

  task automatic reset_mid(input int s, input int wait_cyc);
    req_data   = {4{28'($urandom())}};
    req_valid  = 4'b0010;
    settle_cyc = 4'(s);
    rsp_ready  = 1'b0;
    adv();
    req_valid = 4'd0;
    repeat (wait_cyc) adv();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dp_in", 64'(dp_in), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    settle_cyc = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("reset_idle", {dp_in, rsp_valid, rsp_data, rsp_id, req_ready, busy}, 64'd0);
    end

    do_txn(4'b0100, 3, 1'b0, 1, 1'b1);
    for (int i = 0; i < 6; i++) do_txn(4'hF, 1, 1'b1, 0, 1'b0);
    do_txn(4'b1011, 2, 1'b0, 7, 1'b0);
    do_txn(4'b0110, 0, 1'b0, 0, 1'b0);

    reset_mid(8, 2);
    reset_mid(1, 2);
    do_txn(4'hF, 2, 1'b1, 0, 1'b0);

    for (int i = 0; i < 40; i++)
      do_txn(4'($urandom_range(1, 15)), $urandom_range(0, 6),
             1'($urandom_range(0, 1)), $urandom_range(0, 4), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
